traffic_lights_xing: RTL and testbench

Multi-direction intersection controller. It generalises the single-signal traffic light to `N_DIR` approaches served in round-robin green phases, with an all-red clearance interval between phases. Each approach has its own runtime-programmable green and yellow times and an optional demand input that skips unrequested approaches. It sits between the command interface (`cmd_*`) and the per-approach lamp drivers; it runs at the 2000 Hz system clock.

---
 rtl/traffic_lights_xing.sv | 177 +++++++++++++++++
 tb/tb_traffic_lights_xing.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_xing.sv
// traffic_lights_xing: round-robin multi-approach intersection controller with all-red clearance,
// per-approach programmable green/yellow times, demand skipping, flash and lamps-off modes.
module traffic_lights_xing #(
    parameter int N_DIR                = 2,
    parameter int CLK_HZ               = 2000,
    parameter int BLINK_HALF_PERIOD_MS = 3,
    parameter int BLINK_HALF_PERIODS   = 4,
    parameter int RED_YELLOW_MS        = 7,
    parameter int ALL_RED_MS           = 2,
    parameter bit SKIP_EMPTY           = 1'b0
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [2:0]               cmd_type_i,
    input  logic                     cmd_valid_i,
    input  logic [$clog2(N_DIR)-1:0] cmd_dir_i,
    input  logic [15:0]              cmd_data_i,
    input  logic [N_DIR-1:0]         req_i,
    output logic [N_DIR-1:0]         red_o,
    output logic [N_DIR-1:0]         yellow_o,
    output logic [N_DIR-1:0]         green_o
);
    localparam int DW = $clog2(N_DIR);
    localparam logic [31:0] AR_C = 32'(ALL_RED_MS * CLK_HZ / 1000);
    localparam logic [31:0] RY_C = 32'(RED_YELLOW_MS * CLK_HZ / 1000);
    localparam logic [31:0] BH_C = 32'(BLINK_HALF_PERIOD_MS * CLK_HZ / 1000);
    localparam logic [31:0] BLINK_C = 32'(BLINK_HALF_PERIODS) * BH_C;
    localparam int BW = BH_C > 1 ? $clog2(BH_C) : 1;
    localparam int HW = BLINK_HALF_PERIODS > 1 ? $clog2(BLINK_HALF_PERIODS) : 1;

    typedef enum logic [2:0] {
        ALL_RED, RED_YELLOW, GREEN, GREEN_BLINK, YELLOW, FLASH_YELLOW, LIGHTS_OFF
    } state_t;

    // zero-length parametric states are skipped by jumping to the next occupied one
    localparam state_t START    = (AR_C != 0) ? ALL_RED : ((RY_C != 0) ? RED_YELLOW : GREEN);
    localparam state_t AFTER_AR = (RY_C != 0) ? RED_YELLOW : GREEN;
    localparam state_t AFTER_G  = (BLINK_C != 0) ? GREEN_BLINK : YELLOW;

    state_t          state, nxt;
    logic [DW-1:0]   dir, nxt_dir, rr_dir;
    logic [15:0]     cnt, len;
    logic [BW-1:0]   bcnt;
    logic [HW-1:0]   hp;
    logic [N_DIR-1:0] pend, gmask;
    logic [15:0]     green_t [N_DIR];
    logic [15:0]     yellow_t [N_DIR];
    logic [31:0]     j;
    logic            go, done, bh_end, cfg_ok;

    function automatic logic [DW-1:0] inc(input logic [DW-1:0] d);
        return d == DW'(N_DIR - 1) ? '0 : d + DW'(1);
    endfunction

    function automatic logic [15:0] eff(input logic [15:0] t);
        return t == 16'd0 ? 16'd1 : t;
    endfunction

    always_comb begin
        rr_dir = inc(dir);
        j = '0;
        for (int i = N_DIR - 1; i >= 1; i--) begin
            j = 32'(dir) + 32'(i);
            if (j >= 32'(N_DIR)) j = j - 32'(N_DIR);
            if (SKIP_EMPTY && pend[DW'(j)]) rr_dir = DW'(j);
        end
    end

    always_comb begin
        bh_end = bcnt == BW'(BH_C - 32'd1);
        gmask = (state == GREEN) ? N_DIR'(1) << dir : '0;
        cfg_ok = cmd_valid_i && state == FLASH_YELLOW && 32'(cmd_dir_i) < 32'(N_DIR);
        case (state)
            ALL_RED:       done = 32'(cnt) + 32'd1 >= AR_C;
            RED_YELLOW:    done = 32'(cnt) + 32'd1 >= RY_C;
            GREEN, YELLOW: done = cnt + 16'd1 >= len;
            GREEN_BLINK:   done = bh_end && hp == HW'(BLINK_HALF_PERIODS - 1);
            default:       done = 1'b0;
        endcase
    end

    always_comb begin
        nxt = state;
        nxt_dir = dir;
        go = 1'b0;
        if (cmd_valid_i && cmd_type_i == 3'd1) begin
            nxt = LIGHTS_OFF;
            go = 1'b1;
        end else if (cmd_valid_i && cmd_type_i == 3'd2) begin
            nxt = FLASH_YELLOW;
            go = 1'b1;
        end else if (cmd_valid_i && cmd_type_i == 3'd0 && (state == FLASH_YELLOW || state == LIGHTS_OFF)) begin
            nxt = START;
            nxt_dir = '0;
            go = 1'b1;
        end else if (done) begin
            go = 1'b1;
            case (state)
                ALL_RED:     nxt = AFTER_AR;
                RED_YELLOW:  nxt = GREEN;
                GREEN:       nxt = AFTER_G;
                GREEN_BLINK: nxt = YELLOW;
                YELLOW: begin
                    nxt = START;
                    nxt_dir = rr_dir;
                end
                default:     nxt = state;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= ALL_RED;
            dir <= '0;
            pend <= '0;
            cnt <= '0;
            len <= '0;
            bcnt <= '0;
            hp <= '0;
            for (int i = 0; i < N_DIR; i++) begin
                green_t[i] <= 16'd10;
                yellow_t[i] <= 16'd10;
            end
        end else begin
            pend <= pend | (req_i & ~gmask);
            if (cfg_ok && cmd_type_i == 3'd3) green_t[cmd_dir_i] <= cmd_data_i;
            if (cfg_ok && cmd_type_i == 3'd4) yellow_t[cmd_dir_i] <= cmd_data_i;
            if (go) begin
                state <= nxt;
                dir <= nxt_dir;
                cnt <= '0;
                bcnt <= '0;
                hp <= '0;
                // lengths are latched at entry so later config writes only affect future phases
                if (nxt == GREEN) begin
                    len <= eff(green_t[nxt_dir]);
                    pend[nxt_dir] <= 1'b0;
                end
                if (nxt == YELLOW) len <= eff(yellow_t[dir]);
            end else begin
                if (state != FLASH_YELLOW && state != LIGHTS_OFF) cnt <= cnt + 16'd1;
                if (state == GREEN_BLINK || state == FLASH_YELLOW) begin
                    bcnt <= bh_end ? '0 : bcnt + BW'(1);
                    hp <= bh_end ? hp + HW'(1) : hp;
                end
            end
        end
    end

    always_comb begin
        red_o = '1;
        yellow_o = '0;
        green_o = '0;
        case (state)
            RED_YELLOW: yellow_o[dir] = 1'b1;
            GREEN: begin
                red_o[dir] = 1'b0;
                green_o[dir] = 1'b1;
            end
            GREEN_BLINK: begin
                red_o[dir] = 1'b0;
                green_o[dir] = hp[0];
            end
            YELLOW: begin
                red_o[dir] = 1'b0;
                yellow_o[dir] = 1'b1;
            end
            FLASH_YELLOW: begin
                red_o = '0;
                yellow_o = {N_DIR{~hp[0]}};
            end
            LIGHTS_OFF: red_o = '0;
            default: red_o = '1;
        endcase
    end
endmodule

// File: tb/tb_traffic_lights_xing.sv
// tb_traffic_lights_xing: directed checks of phase sequencing, commands, skipping and reset.
module tb_traffic_lights_xing;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [2:0]  ct = '0;
    logic        cv = 1'b0;
    logic [1:0]  cd = '0;
    logic [15:0] cdata = '0;
    logic [3:0]  req = '0;
    logic [1:0]  r0, y0, g0;
    logic [3:0]  r1, y1, g1;
    logic [2:0]  r2, y2, g2;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    traffic_lights_xing dut0 (
        .clk_i(clk), .arst_i(arst), .cmd_type_i(ct), .cmd_valid_i(cv), .cmd_dir_i(cd[0]),
        .cmd_data_i(cdata), .req_i(req[1:0]), .red_o(r0), .yellow_o(y0), .green_o(g0)
    );

    traffic_lights_xing #(.N_DIR(4), .SKIP_EMPTY(1'b1)) dut1 (
        .clk_i(clk), .arst_i(arst), .cmd_type_i(ct), .cmd_valid_i(cv), .cmd_dir_i(cd),
        .cmd_data_i(cdata), .req_i(req), .red_o(r1), .yellow_o(y1), .green_o(g1)
    );

    traffic_lights_xing #(.N_DIR(3)) dut2 (
        .clk_i(clk), .arst_i(arst), .cmd_type_i(ct), .cmd_valid_i(cv), .cmd_dir_i(cd),
        .cmd_data_i(cdata), .req_i(req[2:0]), .red_o(r2), .yellow_o(y2), .green_o(g2)
    );

    // expected {red,yellow,green} (4 bits each) for n approaches that all use gl/yl, no skipping
    function automatic logic [11:0] exp_lamp(input int n, input int t, input int gl, input int yl);
        int p, d, o;
        logic [3:0] r, y, g, m;
        p = 42 + gl + yl;
        d = (t / p) % n;
        o = t % p;
        m = 4'(1 << d);
        r = 4'((1 << n) - 1);
        y = '0;
        g = '0;
        if (o >= 4 && o < 18) y = m;
        else if (o >= 18 && o < 18 + gl) begin
            r = r & ~m;
            g = m;
        end else if (o >= 18 + gl && o < 42 + gl) begin
            r = r & ~m;
            if (((o - 18 - gl) / 6) % 2 == 1) g = m;
        end else if (o >= 42 + gl) begin
            r = r & ~m;
            y = m;
        end
        return {r, y, g};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        arst = 1'b1;
        cv = 1'b0;
        req = '0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] t, input logic [1:0] d, input logic [15:0] v);
        ct = t;
        cd = d;
        cdata = v;
        cv = 1'b1;
        @(negedge clk);
        cv = 1'b0;
    endtask

    task automatic test_reset();
        logic [11:0] obs, e;
        arst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({r0, y0, g0, r1} !== 10'b11_00_00_1111) begin
            n_bad++;
            $display("FAIL reset_hold got %b want %b", {r0, y0, g0, r1}, 10'b11_00_00_1111);
        end
        arst = 1'b0;
        for (int t = 0; t < 80; t++) begin
            obs = {4'(r0), 4'(y0), 4'(g0)};
            e = exp_lamp(2, t, 10, 10);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL reset_seq t=%0d got %h want %h", t, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flash_and_config();
        logic [11:0] obs, e;
        logic [1:0] eg;
        apply_reset();
        repeat (20) @(negedge clk);
        cmd(3'd2, 2'd0, 16'd0);
        for (int i = 0; i < 12; i++) begin
            e = {4'b0000, (i < 6) ? 4'b0011 : 4'b0000, 4'b0000};
            obs = {4'(r0), 4'(y0), 4'(g0)};
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL flash i=%0d got %h want %h", i, obs, e);
            end
            @(negedge clk);
        end
        cmd(3'd3, 2'd1, 16'd20);
        cmd(3'd0, 2'd0, 16'd0);
        for (int t = 0; t < 102; t++) begin
            if (t < 80) begin
                obs = {4'(r0), 4'(y0), 4'(g0)};
                e = exp_lamp(2, t, 10, 10);
                n_cmp++;
                if (obs !== e) begin
                    n_bad++;
                    $display("FAIL resume_seq t=%0d got %h want %h", t, obs, e);
                end
            end else begin
                eg = (t < 100) ? 2'b10 : 2'b00;
                n_cmp++;
                if (g0 !== eg) begin
                    n_bad++;
                    $display("FAIL green20 t=%0d got %b want %b", t, g0, eg);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cfg_ignored();
        logic [11:0] obs, e;
        apply_reset();
        for (int t = 0; t < 156; t++) begin
            obs = {4'(r0), 4'(y0), 4'(g0)};
            e = exp_lamp(2, t, 10, 10);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL cfg_ignored t=%0d got %h want %h", t, obs, e);
            end
            ct = 3'd3;
            cd = 2'd0;
            cdata = 16'd30;
            cv = (t == 20);
            @(negedge clk);
        end
        cv = 1'b0;
    endtask

    task automatic test_skip();
        apply_reset();
        for (int t = 0; t < 131; t++) begin
            n_cmp++;
            if ((g1 & 4'b1010) !== 4'b0000) begin
                n_bad++;
                $display("FAIL skip_nogreen t=%0d got %b want 0?0?=0", t, g1);
            end
            if (t == 62) begin
                n_cmp++;
                if (r1 !== 4'b1111) begin
                    n_bad++;
                    $display("FAIL skip_allred got %b want 1111", r1);
                end
            end
            if (t == 66) begin
                n_cmp++;
                if ({r1, y1} !== 8'b1111_0100) begin
                    n_bad++;
                    $display("FAIL skip_ry2 got %b want 11110100", {r1, y1});
                end
            end
            if (t == 80) begin
                n_cmp++;
                if (g1 !== 4'b0100) begin
                    n_bad++;
                    $display("FAIL skip_green2 got %b want 0100", g1);
                end
            end
            if (t == 128) begin
                n_cmp++;
                if (y1 !== 4'b1000) begin
                    n_bad++;
                    $display("FAIL skip_next3 got %b want 1000", y1);
                end
            end
            req = (t == 20) ? 4'b0100 : 4'b0000;
            @(negedge clk);
        end
        req = '0;
    endtask

    task automatic test_off();
        logic [11:0] obs, e;
        apply_reset();
        repeat (7) @(negedge clk);
        cmd(3'd1, 2'd0, 16'd0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({r0, y0, g0} !== 6'b0) begin
                n_bad++;
                $display("FAIL lights_off i=%0d got %b want 000000", i, {r0, y0, g0});
            end
            @(negedge clk);
        end
        cmd(3'd0, 2'd0, 16'd0);
        for (int t = 0; t < 6; t++) begin
            obs = {4'(r0), 4'(y0), 4'(g0)};
            e = exp_lamp(2, t, 10, 10);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL off_resume t=%0d got %h want %h", t, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] obs, e;
        apply_reset();
        repeat (35) @(negedge clk);
        n_cmp++;
        if ({r0, y0, g0} !== 6'b10_00_01) begin
            n_bad++;
            $display("FAIL pre_async got %b want 100001", {r0, y0, g0});
        end
        #2 arst = 1'b1;
        #1;
        n_cmp++;
        if ({r0, y0, g0} !== 6'b11_00_00) begin
            n_bad++;
            $display("FAIL async_reset got %b want 110000", {r0, y0, g0});
        end
        @(negedge clk);
        arst = 1'b0;
        for (int t = 0; t < 20; t++) begin
            obs = {4'(r0), 4'(y0), 4'(g0)};
            e = exp_lamp(2, t, 10, 10);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL async_restart t=%0d got %h want %h", t, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cfg_zero();
        logic [11:0] obs, e;
        apply_reset();
        @(negedge clk);
        cmd(3'd2, 2'd0, 16'd0);
        cmd(3'd3, 2'd0, 16'd0);
        cmd(3'd4, 2'd0, 16'd0);
        cmd(3'd0, 2'd0, 16'd0);
        for (int t = 0; t < 56; t++) begin
            obs = {4'(r0), 4'(y0), 4'(g0)};
            e = exp_lamp(2, t, 1, 1);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL cfg_zero t=%0d got %h want %h", t, obs, e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bad_dir();
        logic [11:0] obs, e;
        apply_reset();
        cmd(3'd2, 2'd0, 16'd0);
        cmd(3'd3, 2'd3, 16'd0);
        cmd(3'd4, 2'd3, 16'd0);
        cmd(3'd0, 2'd0, 16'd0);
        for (int t = 0; t < 190; t++) begin
            obs = {4'(r2), 4'(y2), 4'(g2)};
            e = exp_lamp(3, t, 10, 10);
            n_cmp++;
            if (obs !== e) begin
                n_bad++;
                $display("FAIL bad_dir t=%0d got %h want %h", t, obs, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_flash_and_config();
        test_cfg_ignored();
        test_skip();
        test_off();
        test_async_reset();
        test_cfg_zero();
        test_bad_dir();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
